e603_icb_sram_dly_ctrl: RTL and testbench

ICB slave that terminates the memory side of the AXI-to-SRAM subsystem. It sits directly downstream of the AXI-to-ICB bridge and drives a single-port synchronous SRAM macro. Each response is held back by a runtime-programmable number of cycles (delay_select) so that slow memories and DDR-like latency can be emulated. Responses are buffered in a small in-order FIFO so commands can be pipelined when delay is zero.

---
 rtl/e603_icb_sram_dly_ctrl_pkg.sv | 16 +
 rtl/e603_gnrl_rsp_fifo.sv | 62 ++++++
 rtl/e603_icb_sram_dly_ctrl.sv | 130 +++++++++++++
 tb/tb_e603_icb_sram_dly_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e603_icb_sram_dly_ctrl_pkg.sv
// rtl/e603_icb_sram_dly_ctrl_pkg.sv - shared defaults and response entry layout
package e603_icb_sram_dly_ctrl_pkg;

    localparam int DELAY_WIDTH_DEF   = 9;
    localparam int MEM_SIZE_LOG2_DEF = 16;
    localparam int DW_DEF            = 32;

    // A buffered response: error flag sits above the read data
    typedef struct packed {
        logic              err;
        logic [DW_DEF-1:0] rdata;
    } rsp_entry_t;

    localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

endpackage

// File: rtl/e603_gnrl_rsp_fifo.sv
// rtl/e603_gnrl_rsp_fifo.sv - synchronous in-order FIFO with valid/ready on both sides
module e603_gnrl_rsp_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    input  logic [DW-1:0]            i_wdata,
    output logic                     o_rvalid,
    input  logic                     i_rready,
    output logic [DW-1:0]            o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_wready = (r_count != CW'(DEPTH));
    assign o_rvalid = (r_count != '0);
    assign o_rdata  = r_mem[r_rptr];
    assign o_count  = r_count;
    assign w_push   = i_wvalid & o_wready;
    assign w_pop    = i_rready & o_rvalid;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries below r_count are ever observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/e603_icb_sram_dly_ctrl.sv
// rtl/e603_icb_sram_dly_ctrl.sv - ICB slave driving an SRAM with programmable response delay
module e603_icb_sram_dly_ctrl
    import e603_icb_sram_dly_ctrl_pkg::*;
#(
    parameter int AW            = 29,
    parameter int DW            = DW_DEF,
    parameter int MW            = 4,
    parameter int DELAY_WIDTH   = DELAY_WIDTH_DEF,
    parameter int MEM_SIZE_LOG2 = MEM_SIZE_LOG2_DEF,
    parameter int RSP_DEPTH     = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DELAY_WIDTH-1:0]              delay_select,
    input  logic                                icb_cmd_valid,
    output logic                                icb_cmd_ready,
    input  logic                                icb_cmd_read,
    input  logic [AW-1:0]                       icb_cmd_addr,
    input  logic [DW-1:0]                       icb_cmd_wdata,
    input  logic [MW-1:0]                       icb_cmd_wmask,
    output logic                                icb_rsp_valid,
    input  logic                                icb_rsp_ready,
    output logic [DW-1:0]                       icb_rsp_rdata,
    output logic                                icb_rsp_err,
    output logic                                sram_cs,
    output logic                                sram_we,
    output logic [MEM_SIZE_LOG2-$clog2(MW)-1:0] sram_addr,
    output logic [MW-1:0]                       sram_wem,
    output logic [DW-1:0]                       sram_din,
    input  logic [DW-1:0]                       sram_dout
);

    localparam int BW = $clog2(MW);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int EW = DW + 1;

    logic                   w_accept;
    logic                   w_range_err;
    logic [CW-1:0]          w_fifo_count;
    logic [CW-1:0]          w_occupancy;
    logic                   w_fifo_rvalid;
    logic                   w_fifo_wready;
    logic [EW-1:0]          w_fifo_rdata;
    logic                   w_fifo_push;
    logic                   w_fifo_pop;
    logic                   w_bypass;
    logic                   w_rsp_hs;
    logic                   w_load;
    logic [DELAY_WIDTH-1:0] w_load_val;
    logic                   w_new_err;
    logic [DW-1:0]          w_new_rdata;
    logic                   w_unused;

    logic                   r_inflight;
    logic                   r_inflight_err;
    logic                   r_inflight_read;
    logic [DELAY_WIDTH-1:0] r_cnt;

    // Occupancy only counts registered state, so a pop frees a slot one cycle later
    assign w_occupancy   = w_fifo_count + CW'(r_inflight);
    assign icb_cmd_ready = (w_occupancy < CW'(RSP_DEPTH));
    assign w_accept      = icb_cmd_valid & icb_cmd_ready;
    assign w_range_err   = |icb_cmd_addr[AW-1:MEM_SIZE_LOG2];

    assign sram_cs   = w_accept & ~w_range_err;
    assign sram_we   = sram_cs & ~icb_cmd_read;
    assign sram_addr = icb_cmd_addr[MEM_SIZE_LOG2-1:BW];
    assign sram_wem  = sram_cs ? icb_cmd_wmask : '0;
    assign sram_din  = icb_cmd_wdata;

    // One-cycle slot that waits for the SRAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_err  <= 1'b0;
            r_inflight_read <= 1'b0;
        end else begin
            r_inflight      <= w_accept;
            r_inflight_err  <= w_range_err;
            r_inflight_read <= icb_cmd_read;
        end
    end

    assign w_new_err   = r_inflight_err;
    assign w_new_rdata = (r_inflight_read & ~r_inflight_err) ? sram_dout : '0;

    // With zero delay and nothing queued the in-flight entry is presented directly
    assign w_bypass      = r_inflight & ~w_fifo_rvalid & (delay_select == '0);
    assign icb_rsp_valid = w_bypass | (w_fifo_rvalid & (r_cnt == '0));
    assign {icb_rsp_err, icb_rsp_rdata} = w_fifo_rvalid ? w_fifo_rdata
                                                        : {w_new_err, w_new_rdata};

    assign w_rsp_hs    = icb_rsp_valid & icb_rsp_ready;
    assign w_fifo_pop  = w_rsp_hs & w_fifo_rvalid;
    assign w_fifo_push = r_inflight & ~(w_bypass & icb_rsp_ready);

    // A new head appears on a write into an empty FIFO or when a pop exposes another entry
    assign w_load     = (w_fifo_push & ~w_fifo_rvalid)
                      | (w_fifo_pop & ((w_fifo_count > CW'(1)) | w_fifo_push));
    assign w_load_val = (delay_select == '0) ? '0 : delay_select - DELAY_WIDTH'(1);

    // Per-head countdown; the load cycle itself is the first cycle of the delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= w_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DELAY_WIDTH'(1);
        end
    end

    e603_gnrl_rsp_fifo #(
        .DW    (EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wvalid (w_fifo_push),
        .o_wready (w_fifo_wready),
        .i_wdata  ({w_new_err, w_new_rdata}),
        .o_rvalid (w_fifo_rvalid),
        .i_rready (w_fifo_pop),
        .o_rdata  (w_fifo_rdata),
        .o_count  (w_fifo_count)
    );

    assign w_unused = ^{w_fifo_wready, icb_cmd_addr[BW-1:0]};

endmodule

// File: tb/tb_e603_icb_sram_dly_ctrl.sv
// tb/tb_e603_icb_sram_dly_ctrl.sv - directed and randomized bench for e603_icb_sram_dly_ctrl
module tb_e603_icb_sram_dly_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  delay_select;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [28:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        sram_cs;
    logic        sram_we;
    logic [13:0] sram_addr;
    logic [3:0]  sram_wem;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    e603_icb_sram_dly_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .delay_select  (delay_select),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .sram_cs       (sram_cs),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wem      (sram_wem),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
    );

    // Single-port synchronous SRAM macro
    logic [31:0] sram_mem [0:16383];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wem[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic single(input logic rd, input logic [28:0] a, input logic [31:0] d);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = d;
        icb_cmd_wmask = 4'hF;
        tick();
        icb_cmd_valid = 1'b0;
        tick();
    endtask

    // Reference model: word store for the random region and an in-order response queue
    logic [31:0] ref_mem [64];
    logic [32:0] exp_q [$];
    logic [32:0] exp_e;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          idx;
    int          issued;
    int          stale;

    initial begin
        rst_n         = 1'b0;
        delay_select  = '0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;
        repeat (2) tick();
        smp();
        check("reset_cmd_ready", icb_cmd_ready, 1);
        check("reset_rsp_valid", icb_rsp_valid, 0);
        check("reset_sram_cs", sram_cs, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Write then read back with zero delay
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 29'h100;
        icb_cmd_wdata = 32'hDEADBEEF; icb_cmd_wmask = 4'hF;
        smp();
        check("wr_cs", sram_cs, 1);
        check("wr_we", sram_we, 1);
        check("wr_addr", sram_addr, 14'h40);
        check("wr_wem", sram_wem, 4'hF);
        check("wr_din", sram_din, 32'hDEADBEEF);
        tick();
        icb_cmd_valid = 1'b0;
        smp();
        check("wr_rsp_valid", icb_rsp_valid, 1);
        check("wr_rsp_err", icb_rsp_err, 0);
        check("wr_rsp_rdata", icb_rsp_rdata, 0);
        tick();
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1;
        smp();
        check("rd_idle_valid", icb_rsp_valid, 0);
        check("rd_cs", sram_cs, 1);
        check("rd_we", sram_we, 0);
        tick();
        icb_cmd_valid = 1'b0;
        smp();
        check("rd_rsp_valid", icb_rsp_valid, 1);
        check("rd_rsp_rdata", icb_rsp_rdata, 32'hDEADBEEF);
        tick();

        // Delay of 5: valid first at T+6
        delay_select = 9'd5;
        icb_cmd_valid = 1'b1;
        smp();
        tick();
        icb_cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            smp();
            check($sformatf("dly5_valid_T%0d", k), icb_rsp_valid, (k == 6));
            if (k < 6) tick();
        end
        check("dly5_rdata", icb_rsp_rdata, 32'hDEADBEEF);
        tick();

        // Back-pressure: two reads fill the buffer, third waits for a pop
        delay_select = '0;
        single(1'b0, 29'h200, 32'hAAAA0001);
        single(1'b0, 29'h204, 32'hBBBB0002);
        single(1'b0, 29'h208, 32'hCCCC0003);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 29'h200;
        smp(); check("bp_ready_T0", icb_cmd_ready, 1);
        tick();
        icb_cmd_addr = 29'h204;
        smp(); check("bp_ready_T1", icb_cmd_ready, 1);
        tick();
        icb_cmd_addr = 29'h208;
        smp(); check("bp_ready_T2", icb_cmd_ready, 0);
        tick();
        smp();
        check("bp_ready_T3", icb_cmd_ready, 0);
        check("bp_valid_T3", icb_rsp_valid, 1);
        check("bp_rdata_T3", icb_rsp_rdata, 32'hAAAA0001);
        tick();
        icb_rsp_ready = 1'b1;
        smp();
        check("bp_ready_T4", icb_cmd_ready, 0);
        check("bp_rdata_T4", icb_rsp_rdata, 32'hAAAA0001);
        tick();
        smp();
        check("bp_ready_T5", icb_cmd_ready, 1);
        check("bp_valid_T5", icb_rsp_valid, 1);
        check("bp_rdata_T5", icb_rsp_rdata, 32'hBBBB0002);
        tick();
        icb_cmd_valid = 1'b0;
        smp();
        check("bp_valid_T6", icb_rsp_valid, 1);
        check("bp_rdata_T6", icb_rsp_rdata, 32'hCCCC0003);
        tick();
        smp();
        check("bp_valid_T7", icb_rsp_valid, 0);
        tick();

        // Out-of-range read
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 29'h0001_0000; icb_cmd_wmask = 4'hF;
        smp();
        check("oor_cs", sram_cs, 0);
        check("oor_we", sram_we, 0);
        check("oor_wem", sram_wem, 0);
        check("oor_ready", icb_cmd_ready, 1);
        tick();
        icb_cmd_valid = 1'b0;
        smp();
        check("oor_valid", icb_rsp_valid, 1);
        check("oor_err", icb_rsp_err, 1);
        check("oor_rdata", icb_rsp_rdata, 0);
        tick();

        // Delay changed after the head has loaded; second entry uses the new value
        delay_select = 9'd8;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 29'h200;
        smp();
        tick();
        icb_cmd_addr = 29'h204;
        smp();
        check("dchg_valid_T1", icb_rsp_valid, 0);
        tick();
        icb_cmd_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            if (k == 3) delay_select = 9'd2;
            smp();
            check($sformatf("dchg_valid_T%0d", k), icb_rsp_valid, (k == 9));
            if (k < 9) tick();
        end
        check("dchg_rdata_first", icb_rsp_rdata, 32'hAAAA0001);
        tick();
        smp();
        check("dchg_valid_P1", icb_rsp_valid, 0);
        tick();
        smp();
        check("dchg_valid_P2", icb_rsp_valid, 1);
        check("dchg_rdata_second", icb_rsp_rdata, 32'hBBBB0002);
        tick();

        // Reset while a response is waiting
        delay_select = '0;
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_addr = 29'h204;
        smp();
        tick();
        icb_cmd_valid = 1'b0;
        smp();
        check("rst_pending_valid", icb_rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", icb_rsp_valid, 0);
        check("rst_async_ready", icb_cmd_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset during a countdown of 7
        delay_select = 9'd7;
        icb_rsp_ready = 1'b1;
        icb_cmd_valid = 1'b1; icb_cmd_addr = 29'h200;
        smp();
        tick();
        icb_cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_cnt_valid", icb_rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        smp();
        check("rst_release_ready", icb_cmd_ready, 1);
        stale = 0;
        repeat (12) begin
            tick();
            smp();
            if (icb_rsp_valid) stale++;
        end
        check("rst_no_stale", stale, 0);
        tick();

        // Preload the random region so the model knows every word
        delay_select = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom;
            single(1'b0, 29'h1000 + 29'(i * 4), ref_mem[i]);
        end

        // Random traffic against the in-order model
        issued = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (issued >= 150 && exp_q.size() == 0) break;
            if (issued < 150 && $urandom_range(0, 3) != 0) begin
                icb_cmd_valid = 1'b1;
                icb_cmd_read  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0)
                    icb_cmd_addr = 29'($urandom) | 29'h0001_0000;
                else
                    icb_cmd_addr = 29'h1000 + 29'($urandom_range(0, 63) * 4);
                icb_cmd_wdata = $urandom;
                icb_cmd_wmask = 4'($urandom_range(0, 15));
            end else begin
                icb_cmd_valid = 1'b0;
            end
            icb_rsp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) delay_select = 9'($urandom_range(0, 3));
            smp();
            if (icb_rsp_valid && icb_rsp_ready) begin
                check("rnd_rsp_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("rnd_rsp", {icb_rsp_err, icb_rsp_rdata}, exp_e);
                end
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                issued++;
                exp_err = (icb_cmd_addr >= 29'h0001_0000);
                exp_rd  = '0;
                check("rnd_cs", sram_cs, !exp_err);
                if (!exp_err) begin
                    check("rnd_sram_addr", sram_addr, 14'(icb_cmd_addr >> 2));
                    idx = int'((icb_cmd_addr - 29'h1000) >> 2);
                    if (icb_cmd_read) begin
                        exp_rd = ref_mem[idx];
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (icb_cmd_wmask[b]) ref_mem[idx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                        end
                    end
                end
                exp_q.push_back({exp_err, exp_rd});
            end
            tick();
        end
        icb_cmd_valid = 1'b0;
        check("rnd_issued", issued, 150);
        check("rnd_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
